regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Arbitrates two requesters (A, B) onto a single external register file.
//   The register file writes on every edge (no enable) and has a registered
//   1-cycle read. After reset, all 32 registers are cleared (INIT) before
//   arbitration starts (RUN).
//
// Parameters
//   PRIO_A        0: round-robin between A and B; 1: A always wins.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   x_valid/ready requester handshake (x = a, b); transfer = valid & ready
//   x_we, x_rd, x_wdata   optional write of the transfer (rd = 0 is ignored)
//   x_rs, x_rt    read addresses of the transfer
//   rsp_valid_x   response for an x transfer, one cycle after it
//   rsp_data1/2   read data returned by the register file
//   init_done     register-file clear complete
//   rf_*          register-file address/data interface
module regfile_arbiter #(
  parameter bit PRIO_A = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_we,
  input  logic [4:0]  a_rs,
  input  logic [4:0]  a_rt,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_we,
  input  logic [4:0]  b_rs,
  input  logic [4:0]  b_rt,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_wdata,
  output logic        rsp_valid_a,
  output logic        rsp_valid_b,
  output logic [31:0] rsp_data1,
  output logic [31:0] rsp_data2,
  output logic        init_done,
  output logic [4:0]  rf_read_reg1,
  output logic [4:0]  rf_read_reg2,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  input  logic [31:0] rf_read_data1,
  input  logic [31:0] rf_read_data2
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_clr_cnt;
  logic        r_init_done;
  logic        r_last_a;     // most recent transfer was granted to A
  logic        r_rsp_a;
  logic        r_rsp_b;

  logic        w_a_ready;
  logic        w_b_ready;
  logic [4:0]  w_rd_reg1;
  logic [4:0]  w_rd_reg2;
  logic [4:0]  w_wr_reg;
  logic [31:0] w_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
      r_last_a    <= 1'b0;
      r_rsp_a     <= 1'b0;
      r_rsp_b     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rsp_a <= w_a_ready;
      r_rsp_b <= w_b_ready;
      if (r_state == S_INIT) begin
        r_clr_cnt <= r_clr_cnt + 5'd1;
        if (r_clr_cnt == 5'd31) begin
          r_init_done <= 1'b1;
        end
      end
      if (w_a_ready) begin
        r_last_a <= 1'b1;
      end else if (w_b_ready) begin
        r_last_a <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_ready   = 1'b0;
    w_b_ready   = 1'b0;
    w_rd_reg1   = '0;
    w_rd_reg2   = '0;
    w_wr_reg    = '0;
    w_wr_data   = '0;
    case (r_state)
      S_INIT: begin
        // Clear one register per cycle; the write of r31 is the last one.
        w_wr_reg = r_clr_cnt;
        if (r_clr_cnt == 5'd31) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // On contention A wins unless round-robin and A won last time.
        w_a_ready = a_valid & (~b_valid | PRIO_A | ~r_last_a);
        w_b_ready = b_valid & ~w_a_ready;
        if (w_a_ready) begin
          w_rd_reg1 = a_rs;
          w_rd_reg2 = a_rt;
          if (a_we && (a_rd != 5'd0)) begin
            w_wr_reg  = a_rd;
            w_wr_data = a_wdata;
          end
        end else if (w_b_ready) begin
          w_rd_reg1 = b_rs;
          w_rd_reg2 = b_rt;
          if (b_we && (b_rd != 5'd0)) begin
            w_wr_reg  = b_rd;
            w_wr_data = b_wdata;
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign a_ready       = w_a_ready;
  assign b_ready       = w_b_ready;
  assign rsp_valid_a   = r_rsp_a;
  assign rsp_valid_b   = r_rsp_b;
  assign rsp_data1     = rf_read_data1;
  assign rsp_data2     = rf_read_data2;
  assign init_done     = r_init_done;
  assign rf_read_reg1  = w_rd_reg1;
  assign rf_read_reg2  = w_rd_reg2;
  assign rf_write_reg  = w_wr_reg;
  assign rf_write_data = w_wr_data;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the arbiter and the
// register-file contents.
module tb_regfile_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_valid, a_we, b_valid, b_we;
  logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
  logic [31:0] a_wdata, b_wdata;

  logic        a_ready, b_ready, rsp_valid_a, rsp_valid_b, init_done;
  logic [31:0] rsp_data1, rsp_data2, rf_write_data, rf_read_data1, rf_read_data2;
  logic [4:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;

  // second instance with fixed priority; only its grants are checked
  logic        p_a_ready, p_b_ready, p_rsp_valid_a, p_rsp_valid_b, p_init_done;
  logic [31:0] p_rsp_data1, p_rsp_data2, p_rf_write_data;
  logic [4:0]  p_rf_read_reg1, p_rf_read_reg2, p_rf_write_reg;
  logic [31:0] p_rf_read_data1 = '0;
  logic [31:0] p_rf_read_data2 = '0;

  regfile_arbiter #(.PRIO_A(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_rs(a_rs), .a_rt(a_rt),
    .a_rd(a_rd), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_rs(b_rs), .b_rt(b_rt),
    .b_rd(b_rd), .b_wdata(b_wdata),
    .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .init_done(init_done),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
  );

  regfile_arbiter #(.PRIO_A(1'b1)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(p_a_ready), .a_we(a_we), .a_rs(a_rs), .a_rt(a_rt),
    .a_rd(a_rd), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(p_b_ready), .b_we(b_we), .b_rs(b_rs), .b_rt(b_rt),
    .b_rd(b_rd), .b_wdata(b_wdata),
    .rsp_valid_a(p_rsp_valid_a), .rsp_valid_b(p_rsp_valid_b),
    .rsp_data1(p_rsp_data1), .rsp_data2(p_rsp_data2), .init_done(p_init_done),
    .rf_read_reg1(p_rf_read_reg1), .rf_read_reg2(p_rf_read_reg2),
    .rf_write_reg(p_rf_write_reg), .rf_write_data(p_rf_write_data),
    .rf_read_data1(p_rf_read_data1), .rf_read_data2(p_rf_read_data2)
  );

  // External register file: write every edge, registered read, starts dirty.
  logic [31:0] env_mem [32];
  bit          env_seeded = 1'b0;
  always @(posedge clk) begin
    if (!env_seeded) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= $urandom;
      env_seeded <= 1'b1;
    end else begin
      env_mem[rf_write_reg] <= rf_write_data;
    end
    rf_read_data1 <= env_mem[rf_read_reg1];
    rf_read_data2 <= env_mem[rf_read_reg2];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_edges;          // rising edges seen since reset release
  bit          m_last_a;         // last transfer went to A
  bit          m_pend_a, m_pend_b;
  logic [31:0] m_pd1, m_pd2;
  logic [31:0] m_regs [32];
  bit          m_run, m_ga, m_gb, m_pga, m_pgb;
  logic [4:0]  m_rs, m_rt, m_rd, m_wreg;
  logic        m_we;
  logic [31:0] m_wd, m_wdata;

  initial begin
    m_edges = 0; m_last_a = 1'b0; m_pend_a = 1'b0; m_pend_b = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_rsp_a", rsp_valid_a, 0);
      chk("rst_rsp_b", rsp_valid_b, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_p_ready", {p_a_ready, p_b_ready}, 0);
      m_edges = 0; m_last_a = 1'b0; m_pend_a = 1'b0; m_pend_b = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      m_run = (m_edges >= 32);
      chk("init_done", init_done, m_run);
      chk("rsp_valid_a", rsp_valid_a, m_pend_a);
      chk("rsp_valid_b", rsp_valid_b, m_pend_b);
      if (m_pend_a || m_pend_b) begin
        chk("rsp_data1", rsp_data1, m_pd1);
        chk("rsp_data2", rsp_data2, m_pd2);
      end
      m_ga = 1'b0; m_gb = 1'b0; m_pga = 1'b0; m_pgb = 1'b0;
      if (m_run) begin
        if (a_valid && b_valid) begin
          // alternate: whoever did not win the last transfer wins now
          if (m_last_a) m_gb = 1'b1; else m_ga = 1'b1;
          m_pga = 1'b1;
        end else begin
          m_ga = a_valid; m_gb = b_valid;
          m_pga = a_valid; m_pgb = b_valid;
        end
      end
      chk("a_ready", a_ready, m_ga);
      chk("b_ready", b_ready, m_gb);
      chk("prio_a_ready", p_a_ready, m_pga);
      chk("prio_b_ready", p_b_ready, m_pgb);
      m_wreg = 5'd0; m_wdata = '0;
      if (!m_run) begin
        m_wreg = m_edges[4:0];
        chk("init_rd_regs", {rf_read_reg1, rf_read_reg2}, 0);
      end else if (m_ga || m_gb) begin
        m_rs = m_ga ? a_rs : b_rs;       m_rt = m_ga ? a_rt : b_rt;
        m_rd = m_ga ? a_rd : b_rd;       m_we = m_ga ? a_we : b_we;
        m_wd = m_ga ? a_wdata : b_wdata;
        chk("rf_read_reg1", rf_read_reg1, m_rs);
        chk("rf_read_reg2", rf_read_reg2, m_rt);
        if (m_we && m_rd != 0) begin
          m_wreg = m_rd; m_wdata = m_wd;
        end
      end
      chk("rf_write_reg", rf_write_reg, m_wreg);
      chk("rf_write_data", rf_write_data, m_wdata);
      // advance model across the coming rising edge
      m_pend_a = m_ga; m_pend_b = m_gb;
      if (m_ga || m_gb) begin
        m_pd1 = m_regs[m_rs]; m_pd2 = m_regs[m_rt];   // pre-write values
        m_last_a = m_ga;
      end
      m_regs[m_wreg] = m_wdata;
      if (m_edges < 32) m_edges++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_we = 0; a_rs = 0; a_rt = 0; a_rd = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_rs = 0; b_rt = 0; b_rd = 0; b_wdata = 0;
  endtask

  bit rec_a [4];
  bit rec_b [4];

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    a_valid = 1'b1;
    rst_n = 1'b1;
    repeat (31) step();
    chk("init_done_at_31", init_done, 0);
    chk("a_ready_held_in_init", a_ready, 0);
    step();
    chk("init_done_at_32", init_done, 1);

    // read every register after the clear
    for (int r = 0; r < 32; r++) begin
      a_rs = r[4:0]; a_rt = 5'(31 - r);
      step();
    end
    a_valid = 0;
    step();

    // write r5, then read it back
    a_valid = 1; a_we = 1; a_rd = 5; a_wdata = 32'hDEADBEEF; a_rs = 0; a_rt = 0;
    step();
    a_we = 0; a_rs = 5;
    step();
    chk("wr5_rsp_valid_a", rsp_valid_a, 1);
    chk("wr5_rsp_data1", rsp_data1, 32'hDEADBEEF);

    // a B transfer so that A is favoured, then 4 contended cycles
    idle_inputs();
    b_valid = 1;
    step();
    a_valid = 1; b_valid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      rec_a[k] = a_ready; rec_b[k] = b_ready;
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant_a", rec_a[k], (k % 2) == 0);
      chk("rr_grant_b", rec_b[k], (k % 2) == 1);
    end

    // B write to r0 is suppressed
    idle_inputs();
    b_valid = 1; b_we = 1; b_rd = 0; b_wdata = 32'h12345678;
    #1;
    chk("r0_b_ready", b_ready, 1);
    chk("r0_write_reg", rf_write_reg, 0);
    chk("r0_write_data", rf_write_data, 0);
    step();
    idle_inputs();
    a_valid = 1;
    step();
    chk("r0_read_rsp", rsp_valid_a, 1);
    chk("r0_read_data", rsp_data1, 0);

    // no forwarding within a transfer
    a_we = 1; a_rd = 7; a_wdata = 32'hA5A5A5A5; a_rs = 7;
    step();
    chk("nofwd_old", rsp_data1, 0);
    a_we = 0;
    step();
    chk("nofwd_new", rsp_data1, 32'hA5A5A5A5);

    // reset while a response is in flight
    a_rs = 5;
    step();
    chk("pre_rst_rsp", rsp_valid_a, 1);
    rst_n = 0;
    #1;
    chk("rst_drops_rsp", rsp_valid_a, 0);
    chk("rst_drops_ready", a_ready, 0);
    chk("rst_clears_done", init_done, 0);
    step();
    step();
    rst_n = 1;
    repeat (31) step();
    chk("reinit_done_at_31", init_done, 0);
    step();
    chk("reinit_done_at_32", init_done, 1);
    step();
    chk("reinit_r5_cleared", rsp_data1, 0);

    // randomized traffic with occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      a_we = $urandom_range(0, 1); b_we = $urandom_range(0, 1);
      a_rs = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a_rt = 5'($urandom_range(0, 7));
      a_rd = 5'($urandom_range(0, 7));
      b_rs = 5'($urandom_range(0, 7));
      b_rt = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      b_rd = 5'($urandom_range(0, 7));
      a_wdata = $urandom; b_wdata = $urandom;
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 599) == 0) rst_n = 0;
      step();
    end
    rst_n = 1;
    idle_inputs();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
